// File: rtl/dec_out_packer.sv
// Drains one hard-decision RAM bank bit-serially and packs the bits LSB-first into OUT_WIDTH-bit stream words.
// Optional feature: define DEC_OUT_PARITY_EN to add the m_parity output (XOR of m_data, qualified by m_valid).
module dec_out_packer #(
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  bank_sel,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [1:0]            ram_cs,
    input  logic [1:0]            ram_data,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
`ifdef DEC_OUT_PARITY_EN
    output logic                  m_parity,
`endif
    output logic                  busy,
    output logic                  done
);

    localparam int NWORDS = RAM_DEPTH / OUT_WIDTH;
    localparam int BIT_W  = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam logic [BIT_W-1:0]      LAST_BIT  = BIT_W'(OUT_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        EMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [ADDR_WIDTH-1:0]   word_q, word_d;
    logic                    bank_q, bank_d;
    logic                    fetch_d1_q, fetch_d1_d;
    logic [OUT_WIDTH-1:0]    m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;
    logic                    done_q, done_d;
    logic [OUT_WIDTH-1:0]    sh_q;
    logic                    rd_bit;
`ifdef DEC_OUT_PARITY_EN
    logic                    par_q, par_d;
`endif

    // Read data lags the address by one cycle, so the bank in use stays latched.
    assign rd_bit = ram_data[bank_q];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        bit_d      = bit_q;
        word_d     = word_q;
        bank_d     = bank_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        done_d     = 1'b0;
        fetch_d1_d = (state_q == FETCH);
        ram_cs     = 2'b00;
`ifdef DEC_OUT_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    bank_d  = bank_sel;
                    addr_d  = '0;
                    bit_d   = '0;
                    word_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ram_cs = bank_q ? 2'b10 : 2'b01;
                // Saturate at the top address so a full-depth bank never wraps.
                if (addr_q != LAST_ADDR) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
                if (bit_q == LAST_BIT) begin
                    bit_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            CAPTURE: begin
                m_data_d = {rd_bit, sh_q[OUT_WIDTH-1:1]};
                m_last_d = (word_q == LAST_WORD);
`ifdef DEC_OUT_PARITY_EN
                par_d    = ^{rd_bit, sh_q[OUT_WIDTH-1:1]};
`endif
                state_d  = EMIT;
            end
            EMIT: begin
                if (m_ready) begin
                    m_last_d = 1'b0;
`ifdef DEC_OUT_PARITY_EN
                    par_d    = 1'b0;
`endif
                    if (word_q == LAST_WORD) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        word_d  = word_q + ADDR_WIDTH'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            bit_q      <= '0;
            word_q     <= '0;
            bank_q     <= 1'b0;
            fetch_d1_q <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            bit_q      <= bit_d;
            word_q     <= word_d;
            bank_q     <= bank_d;
            fetch_d1_q <= fetch_d1_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            done_q     <= done_d;
        end
    end

`ifdef DEC_OUT_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign m_parity = par_q;
`endif

    // Bits arrive at the MSB and shift down, so the first fetched bit ends up in bit 0.
    always_ff @(posedge clk) begin
        if (fetch_d1_q) begin
            sh_q <= {rd_bit, sh_q[OUT_WIDTH-1:1]};
        end
    end

    assign ram_address = addr_q;
    assign m_data      = m_data_q;
    assign m_valid     = (state_q == EMIT);
    assign m_last      = m_last_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule
